// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM: states,
// opcodes, ALUOp codes and datapath mux selects.
package multi_cycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EXEC   = 4'd10,
      S_I_WB     = 4'd11,
      S_JAL      = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [2:0] ALUOP_RTYPE = 3'b000;
   localparam logic [2:0] ALUOP_ADD   = 3'b100;
   localparam logic [2:0] ALUOP_SUB   = 3'b010;
   localparam logic [2:0] ALUOP_SLT   = 3'b001;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RA = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] PC_INC_SEL  = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] BR_OFF_SEL  = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_known(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
         OP_ADDI, OP_SLTI, OP_J, OP_JAL: op_known = 1'b1;
         default:                        op_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_next_state.sv
// Combinational next-state logic for the multi-cycle control FSM.
module ctrl_next_state
   import multi_cycle_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output state_e     state_d_o
);

   always_comb begin
      state_d_o = S_FETCH;
      case (state_i)
         S_FETCH:    state_d_o = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               OP_RTYPE:       state_d_o = S_R_EXEC;
               OP_LW, OP_SW:   state_d_o = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d_o = S_BRANCH;
               OP_ADDI,
               OP_SLTI:        state_d_o = S_I_EXEC;
               OP_J:           state_d_o = S_JUMP;
               OP_JAL:         state_d_o = S_JAL;
               default:        state_d_o = S_FETCH;
            endcase
         end
         S_MEM_ADDR: state_d_o = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d_o = mem_ready_i ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_d_o = mem_ready_i ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   state_d_o = S_R_WB;
         S_I_EXEC:   state_d_o = S_I_WB;
         default:    state_d_o = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences ALU, memory
// port, register file and PC, stalling on the memory ready handshake.
//
//  state    | meaning
//  FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
//  DECODE   | latch opcode, branch target into ALUOut, dispatch
//  MEM_ADDR | A + sext imm for lw/sw
//  MEM_RD   | data read at ALUOut, wait for ready
//  MEM_WB   | MDR into rt
//  MEM_WR   | data write at ALUOut, wait for ready
//  R_EXEC   | A op B under funct control
//  R_WB     | ALUOut into rd
//  BRANCH   | A - B, conditional PC load from ALUOut
//  JUMP     | PC <= jump target
//  I_EXEC   | A op sext imm (addi/slti)
//  I_WB     | ALUOut into rt
//  JAL      | PC <= jump target, $31 <= PC
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       reg_write_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_src_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   state_e     state_q, state_d;
   logic [5:0] opcode_q, opcode_d;
   logic [5:0] opcode_eff;

   // DECODE dispatches on the live opcode; later states only see the latched copy.
   assign opcode_eff = (state_q == S_DECODE) ? opcode_i : opcode_q;
   assign opcode_d   = (state_q == S_DECODE) ? opcode_i : opcode_q;

   ctrl_next_state u_next_state (
      .state_i     (state_q),
      .opcode_i    (opcode_eff),
      .mem_ready_i (mem_ready_i),
      .state_d_o   (state_d)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = REG_DST_RT;
      mem_to_reg_o = WB_ALUOUT;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_B;
      alu_op_o     = ALUOP_RTYPE;
      pc_src_o     = PCSRC_ALU;
      illegal_o    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = PC_INC_SEL;
            alu_op_o    = ALUOP_ADD;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         S_DECODE: begin
            alu_src_b_o = BR_OFF_SEL;
            alu_op_o    = ALUOP_ADD;
            illegal_o   = !op_known(opcode_i);
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = REG_DST_RT;
            mem_to_reg_o = WB_MDR;
         end
         S_MEM_WR: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_B;
            alu_op_o    = ALUOP_RTYPE;
         end
         S_R_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = REG_DST_RD;
            mem_to_reg_o = WB_ALUOUT;
         end
         S_I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = (opcode_q == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
         end
         S_I_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = REG_DST_RT;
            mem_to_reg_o = WB_ALUOUT;
         end
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_B;
            alu_op_o    = ALUOP_SUB;
            pc_src_o    = PCSRC_ALUOUT;
            pc_write_o  = (opcode_q == OP_BNE) ? !zero_i : zero_i;
         end
         S_JUMP: begin
            pc_write_o = 1'b1;
            pc_src_o   = PCSRC_JUMP;
         end
         S_JAL: begin
            pc_write_o   = 1'b1;
            pc_src_o     = PCSRC_JUMP;
            reg_write_o  = 1'b1;
            reg_dst_o    = REG_DST_RA;
            mem_to_reg_o = WB_PC;
         end
         default: ;
      endcase
      // Outputs are held quiet for the whole time reset is asserted, not just at the edge.
      if (!rst_i) begin
         pc_write_o   = 1'b0;
         ir_write_o   = 1'b0;
         i_or_d_o     = 1'b0;
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         reg_write_o  = 1'b0;
         reg_dst_o    = 2'b00;
         mem_to_reg_o = 2'b00;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = 2'b00;
         alu_op_o     = 3'b000;
         pc_src_o     = 2'b00;
         illegal_o    = 1'b0;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: inputs change on the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_multi_cycle_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [5:0] opcode_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o;
   logic       reg_write_o, alu_src_a_o, illegal_o;
   logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   multi_cycle_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .opcode_i     (opcode_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .pc_write_o   (pc_write_o),
      .ir_write_o   (ir_write_o),
      .i_or_d_o     (i_or_d_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .reg_write_o  (reg_write_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .pc_src_o     (pc_src_o),
      .illegal_o    (illegal_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic settle();
      #1;
   endtask

   // Branch from FETCH through DECODE into BRANCH, then back to FETCH.
   task automatic run_branch(input string tag, input logic [5:0] op, input logic z,
                             input logic exp_pw);
      opcode_i = op; mem_ready_i = 1'b1; zero_i = 1'b0;
      settle(); chk({tag, " fetch"}, state_o, 0);
      tick(); settle(); chk({tag, " decode"}, state_o, 1);
      tick(); zero_i = z; settle();
      chk({tag, " state"}, state_o, 8);
      chk({tag, " pc_write"}, pc_write_o, exp_pw);
      chk({tag, " alu_op"}, alu_op_o, 3'b010);
      chk({tag, " pc_src"}, pc_src_o, 2'b01);
      tick(); settle(); chk({tag, " back"}, state_o, 0);
   endtask

   initial begin
      rst_i = 1'b1; opcode_i = 6'b000000; zero_i = 1'b0; mem_ready_i = 1'b1;
      #1 rst_i = 1'b0;
      repeat (3) tick();
      settle();
      chk("rst state", state_o, 0);
      chk("rst mem_read", mem_read_o, 0);
      chk("rst ir_write", ir_write_o, 0);
      chk("rst pc_write", pc_write_o, 0);
      chk("rst alu_src_b", alu_src_b_o, 0);
      chk("rst alu_op", alu_op_o, 0);

      // add: 0,1,6,7,0
      rst_i = 1'b1; settle();
      chk("add fetch", state_o, 0);
      chk("add fetch mem_read", mem_read_o, 1);
      chk("add fetch ir_write", ir_write_o, 1);
      chk("add fetch pc_write", pc_write_o, 1);
      chk("add fetch alu_src_b", alu_src_b_o, 2'b01);
      chk("add fetch alu_op", alu_op_o, 3'b100);
      tick(); settle();
      chk("add decode", state_o, 1);
      chk("add decode alu_src_b", alu_src_b_o, 2'b11);
      chk("add decode reg_write", reg_write_o, 0);
      tick(); settle();
      chk("add exec", state_o, 6);
      chk("add exec alu_op", alu_op_o, 3'b000);
      chk("add exec alu_src_a", alu_src_a_o, 1);
      chk("add exec reg_write", reg_write_o, 0);
      tick(); settle();
      chk("add wb", state_o, 7);
      chk("add wb reg_write", reg_write_o, 1);
      chk("add wb reg_dst", reg_dst_o, 2'b01);
      tick(); settle();
      chk("add done", state_o, 0);
      chk("add done reg_write", reg_write_o, 0);

      // FETCH stall
      mem_ready_i = 1'b0; settle();
      chk("stall ir_write", ir_write_o, 0);
      chk("stall pc_write", pc_write_o, 0);
      tick(); settle();
      chk("stall state", state_o, 0);

      // lw with 2 wait states; opcode_i changes after DECODE
      opcode_i = 6'b100011; mem_ready_i = 1'b1;
      tick(); settle(); chk("lw decode", state_o, 1);
      tick(); opcode_i = 6'b101011; settle();
      chk("lw addr", state_o, 2);
      chk("lw addr srcb", alu_src_b_o, 2'b10);
      chk("lw addr srca", alu_src_a_o, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); mem_ready_i = (i == 2); settle();
         chk("lw rd state", state_o, 3);
         chk("lw rd mem_read", mem_read_o, 1);
         chk("lw rd i_or_d", i_or_d_o, 1);
         chk("lw rd reg_write", reg_write_o, 0);
      end
      tick(); settle();
      chk("lw wb state", state_o, 4);
      chk("lw wb reg_write", reg_write_o, 1);
      chk("lw wb mem_to_reg", mem_to_reg_o, 2'b01);
      chk("lw wb reg_dst", reg_dst_o, 2'b00);
      tick(); settle();
      chk("lw done", state_o, 0);
      chk("lw done reg_write", reg_write_o, 0);

      // slti: ALUOp slt in I_EXEC, then I_WB
      opcode_i = 6'b001010;
      tick(); tick(); settle();
      chk("slti exec", state_o, 10);
      chk("slti alu_op", alu_op_o, 3'b001);
      tick(); settle();
      chk("slti wb", state_o, 11);
      chk("slti wb reg_write", reg_write_o, 1);
      tick(); settle();

      run_branch("beq z1", 6'b000100, 1'b1, 1'b1);
      run_branch("beq z0", 6'b000100, 1'b0, 1'b0);
      run_branch("bne z0", 6'b000101, 1'b0, 1'b1);
      run_branch("bne z1", 6'b000101, 1'b1, 1'b0);

      // jal: 0,1,12,0
      opcode_i = 6'b000011;
      tick(); settle(); chk("jal decode", state_o, 1);
      tick(); settle();
      chk("jal state", state_o, 12);
      chk("jal pc_write", pc_write_o, 1);
      chk("jal reg_write", reg_write_o, 1);
      chk("jal reg_dst", reg_dst_o, 2'b10);
      chk("jal mem_to_reg", mem_to_reg_o, 2'b10);
      chk("jal pc_src", pc_src_o, 2'b10);
      tick(); settle(); chk("jal done", state_o, 0);

      // illegal opcode
      opcode_i = 6'b111111; settle();
      chk("ill fetch pulse", illegal_o, 0);
      tick(); settle();
      chk("ill decode", state_o, 1);
      chk("ill pulse", illegal_o, 1);
      chk("ill reg_write", reg_write_o, 0);
      chk("ill mem_write", mem_write_o, 0);
      chk("ill pc_write", pc_write_o, 0);
      tick(); settle();
      chk("ill back", state_o, 0);
      chk("ill pulse gone", illegal_o, 0);

      // sw stalled in MEM_WR, then asynchronous reset mid-cycle
      opcode_i = 6'b101011;
      tick(); tick(); mem_ready_i = 1'b0; tick(); settle();
      chk("sw wr state", state_o, 5);
      chk("sw wr mem_write", mem_write_o, 1);
      #2 rst_i = 1'b0;
      #1;
      chk("async mem_write", mem_write_o, 0);
      chk("async state", state_o, 0);
      tick();
      mem_ready_i = 1'b1; rst_i = 1'b1; settle();
      chk("release state", state_o, 0);
      tick(); settle();
      chk("release decode", state_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
